uart_top: RTL and testbench

UART_TOP -- requirements
Module: uart_top

---
 rtl/uart_pkg.sv | 10 +
 rtl/uart_fifo.sv | 37 +++
 rtl/uart_top.sv | 180 ++++++++++++++++++
 tb/tb_uart_top.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: UART default parameters and RX/TX FSM state types shared by uart_top and uart_fifo
package uart_pkg;
  localparam int UART_DBIT = 8;
  localparam int UART_DB_TICK = 16;
  localparam int UART_SB_TICK = 16;
  localparam int UART_DVSR = 27;
  localparam int UART_FIFO_AW = 4;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: first-word-fall-through FIFO (W x 2**AW); ports clk, rst_n, wr/wdata, rd/rdata (0 when empty), empty, full
module uart_fifo import uart_pkg::*; #(
  parameter int W = 8,
  parameter int AW = UART_FIFO_AW
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr,
  input  logic         rd,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);
  localparam int DEPTH = 2 ** AW;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] cnt;
  logic we, re;
  assign empty = cnt == '0;
  assign full = cnt == (AW+1)'(DEPTH);
  assign we = wr & ~full;
  assign re = rd & ~empty;
  assign rdata = empty ? '0 : mem[rptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt <= '0;
    end else begin
      wptr <= wptr + AW'(we);
      rptr <= rptr + AW'(re);
      cnt <= cnt + (AW+1)'(we) - (AW+1)'(re);
    end
  always_ff @(posedge clk)
    if (we) mem[wptr] <= wdata;
endmodule

// File: rtl/uart_top.sv
// uart_top: UART with baud gen, RX/TX FSMs, TX/RX FIFOs; ports clk, rst_n, wr_en/wr_data/tx_full, rd_en/rd_data/rx_empty, rx, tx; macro UART_PARITY_EN adds even parity
module uart_top import uart_pkg::*; #(
  parameter int DBIT = UART_DBIT,
  parameter int DB_TICK = UART_DB_TICK,
  parameter int SB_TICK = UART_SB_TICK,
  parameter int DVSR = UART_DVSR,
  parameter int FIFO_AW = UART_FIFO_AW
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic       rd_en,
  input  logic [7:0] wr_data,
  input  logic       rx,
  output logic       tx,
  output logic [7:0] rd_data,
  output logic       rx_empty,
  output logic       tx_full
);
`ifdef UART_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NB = DBIT + PB;
  localparam int DW = $clog2(DVSR + 1);
  localparam int SW = $clog2((DB_TICK > SB_TICK ? DB_TICK : SB_TICK) + 1);
  localparam int NW = $clog2(NB + 1);
  logic [DW-1:0] div;
  logic tick;
  logic [1:0] sync;
  logic rx_s;
  assign tick = div == DW'(DVSR - 1);
  assign rx_s = sync[1];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      div <= '0;
      sync <= 2'b11;
    end else begin
      div <= tick ? '0 : div + 1'b1;
      sync <= {sync[0], rx};
    end
  rx_state_t rs, rs_n;
  logic [SW-1:0] rsc, rsc_n;
  logic [NW-1:0] rn, rn_n;
  logic [NB-1:0] rb, rb_n;
  logic rx_done, rx_full, par_ok;
  logic [7:0] rx_byte;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rs <= RX_IDLE;
      rsc <= '0;
      rn <= '0;
      rb <= '0;
    end else begin
      rs <= rs_n;
      rsc <= rsc_n;
      rn <= rn_n;
      rb <= rb_n;
    end
  always_comb begin
    rs_n = rs;
    rsc_n = rsc;
    rn_n = rn;
    rb_n = rb;
    case (rs)
      RX_IDLE: if (!rx_s) begin
        rs_n = RX_START;
        rsc_n = '0;
      end
      RX_START: if (tick) begin
        if (rsc == SW'(DB_TICK / 2 - 1)) begin
          rs_n = rx_s ? RX_IDLE : RX_DATA;
          rsc_n = '0;
          rn_n = '0;
        end else rsc_n = rsc + 1'b1;
      end
      RX_DATA: if (tick) begin
        if (rsc == SW'(DB_TICK - 1)) begin
          rsc_n = '0;
          rb_n = {rx_s, rb[NB-1:1]};
          rn_n = rn + 1'b1;
          if (rn == NW'(NB - 1)) rs_n = RX_STOP;
        end else rsc_n = rsc + 1'b1;
      end
      default: if (tick) begin
        if (rsc == SW'(SB_TICK - 1)) rs_n = RX_IDLE;
        else rsc_n = rsc + 1'b1;
      end
    endcase
  end
  always_comb begin
`ifdef UART_PARITY_EN
    par_ok = ~^rb;
`else
    par_ok = 1'b1;
`endif
    rx_done = rs == RX_STOP && tick && rsc == SW'(SB_TICK - 1) && par_ok;
    rx_byte = 8'(rb[DBIT-1:0]);
  end
  tx_state_t ts, ts_n;
  logic [SW-1:0] tsc, tsc_n;
  logic [NW-1:0] tn, tn_n;
  logic [NB-1:0] tb, tb_n, tx_load;
  logic tx_pop, tx_fempty;
  logic [7:0] tx_head;
`ifdef UART_PARITY_EN
  assign tx_load = {^tx_head[DBIT-1:0], tx_head[DBIT-1:0]};
`else
  assign tx_load = tx_head[DBIT-1:0];
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ts <= TX_IDLE;
      tsc <= '0;
      tn <= '0;
      tb <= '0;
    end else begin
      ts <= ts_n;
      tsc <= tsc_n;
      tn <= tn_n;
      tb <= tb_n;
    end
  always_comb begin
    ts_n = ts;
    tsc_n = tsc;
    tn_n = tn;
    tb_n = tb;
    if (tx_pop) begin
      ts_n = TX_START;
      tsc_n = '0;
      tb_n = tx_load;
    end else case (ts)
      TX_START: if (tick) begin
        if (tsc == SW'(DB_TICK - 1)) begin
          ts_n = TX_DATA;
          tsc_n = '0;
          tn_n = '0;
        end else tsc_n = tsc + 1'b1;
      end
      TX_DATA: if (tick) begin
        if (tsc == SW'(DB_TICK - 1)) begin
          tsc_n = '0;
          tb_n = tb >> 1;
          tn_n = tn + 1'b1;
          if (tn == NW'(NB - 1)) ts_n = TX_STOP;
        end else tsc_n = tsc + 1'b1;
      end
      TX_STOP: if (tick) begin
        if (tsc == SW'(SB_TICK - 1)) ts_n = TX_IDLE;
        else tsc_n = tsc + 1'b1;
      end
      default: ;
    endcase
  end
  always_comb begin
    tx_pop = tick && !tx_fempty && (ts == TX_IDLE || (ts == TX_STOP && tsc == SW'(SB_TICK - 1)));
    tx = ts == TX_START ? 1'b0 : ts == TX_DATA ? tb[0] : 1'b1;
  end
  uart_fifo #(.W(8), .AW(FIFO_AW)) u_tx_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .wr(wr_en),
    .rd(tx_pop),
    .wdata(wr_data),
    .rdata(tx_head),
    .empty(tx_fempty),
    .full(tx_full)
  );
  uart_fifo #(.W(8), .AW(FIFO_AW)) u_rx_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .wr(rx_done & ~rx_full),
    .rd(rd_en),
    .wdata(rx_byte),
    .rdata(rd_data),
    .empty(rx_empty),
    .full(rx_full)
  );
endmodule

// File: tb/tb_uart_top.sv
// tb_uart_top: scoreboard bench driving two cross-connected uart_top instances (A transmits, B receives)
module tb_uart_top;
  localparam int DVSR = 8;
`ifdef UART_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int BIT = 16 * DVSR;
  localparam int FRAME = (10 + PB) * BIT;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic a_wr = 1'b0, a_rd = 1'b0, b_wr = 1'b0, b_rd = 1'b0, b_rx_drv = 1'b1;
  logic [7:0] a_wdata = 8'h00, b_wdata = 8'h00, a_rdata, b_rdata;
  logic a_tx, b_tx, b_rx, a_rx_empty, b_rx_empty, a_tx_full, b_tx_full;
  int total = 0, bad = 0;
  logic [7:0] exp_q[$];
  assign b_rx = a_tx & b_rx_drv;
  always #10 clk = ~clk;
  uart_top #(.DVSR(DVSR)) u_a (
    .clk(clk), .rst_n(rst_n), .wr_en(a_wr), .rd_en(a_rd), .wr_data(a_wdata), .rx(b_tx),
    .tx(a_tx), .rd_data(a_rdata), .rx_empty(a_rx_empty), .tx_full(a_tx_full)
  );
  uart_top #(.DVSR(DVSR)) u_b (
    .clk(clk), .rst_n(rst_n), .wr_en(b_wr), .rd_en(b_rd), .wr_data(b_wdata), .rx(b_rx),
    .tx(b_tx), .rd_data(b_rdata), .rx_empty(b_rx_empty), .tx_full(b_tx_full)
  );
  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic write_a(input logic [7:0] d);
    a_wdata = d;
    a_wr = 1'b1;
    clks(1);
    a_wr = 1'b0;
  endtask
  task automatic pop_b(output logic [7:0] got);
    got = b_rdata;
    b_rd = 1'b1;
    clks(1);
    b_rd = 1'b0;
  endtask
  task automatic wait_a_low(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4 * FRAME && !ok; i++)
      if (a_tx === 1'b0) ok = 1'b1;
      else clks(1);
  endtask
  task automatic test_reset;
    #5 rst_n = 1'b0;
    clks(5);
    total++; if (a_tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b want 1", a_tx); end
    total++; if (b_rx_empty !== 1'b1) begin bad++; $display("FAIL reset_rx_empty: got %b want 1", b_rx_empty); end
    total++; if (a_tx_full !== 1'b0) begin bad++; $display("FAIL reset_tx_full: got %b want 0", a_tx_full); end
    total++; if (b_rdata !== 8'h00) begin bad++; $display("FAIL reset_rd_data: got %h want 00", b_rdata); end
    rst_n = 1'b1;
    clks(2);
  endtask
  task automatic test_tx_frame;
    bit ok;
    int low;
    logic [7:0] bits, got, e;
    write_a(8'hA5);
    exp_q.push_back(8'hA5);
    wait_a_low(ok);
    total++; if (!ok) begin bad++; $display("FAIL frame_start: tx never went low"); end
    low = 0;
    while (a_tx === 1'b0 && low < 2 * BIT) begin
      low++;
      clks(1);
    end
    total++; if (low != BIT) begin bad++; $display("FAIL start_len: got %0d clks want %0d", low, BIT); end
    for (int i = 0; i < 8; i++) begin
      clks(BIT / 2);
      bits[i] = a_tx;
      clks(BIT / 2);
    end
    total++; if (bits !== 8'hA5) begin bad++; $display("FAIL data_bits: got %h want a5", bits); end
`ifdef UART_PARITY_EN
    clks(BIT / 2);
    total++; if (a_tx !== 1'b0) begin bad++; $display("FAIL parity_bit: got %b want 0", a_tx); end
    clks(BIT / 2);
`endif
    clks(BIT / 2);
    total++; if (a_tx !== 1'b1) begin bad++; $display("FAIL stop_bit: got %b want 1", a_tx); end
    clks(FRAME);
    total++; if (b_rx_empty !== 1'b0) begin bad++; $display("FAIL a5_arrived: rx_empty=%b want 0", b_rx_empty); end
    pop_b(got);
    e = exp_q.size() ? exp_q.pop_front() : 8'hxx;
    total++; if (got !== e) begin bad++; $display("FAIL a5_data: got %h want %h", got, e); end
    total++; if (b_rx_empty !== 1'b1) begin bad++; $display("FAIL a5_drained: rx_empty=%b want 1", b_rx_empty); end
  endtask
  task automatic test_reset_mid;
    bit ok;
    write_a(8'h3C);
    wait_a_low(ok);
    total++; if (!ok) begin bad++; $display("FAIL mid_start: tx never went low"); end
    clks(3 * BIT);
    rst_n = 1'b0;
    #1;
    total++; if (a_tx !== 1'b1) begin bad++; $display("FAIL mid_reset_tx: got %b want 1", a_tx); end
    clks(2);
    rst_n = 1'b1;
    clks(2 * FRAME);
    total++; if (a_tx !== 1'b1) begin bad++; $display("FAIL mid_idle_tx: got %b want 1", a_tx); end
    total++; if (b_rx_empty !== 1'b1) begin bad++; $display("FAIL mid_no_rx: rx_empty=%b want 1", b_rx_empty); end
  endtask
  task automatic test_loopback;
    logic [7:0] got, e;
    for (int i = 0; i < 3; i++) begin
      write_a(8'h55 + 8'(i));
      exp_q.push_back(8'h55 + 8'(i));
    end
    clks(4 * FRAME);
    total++; if (b_rx_empty !== 1'b0) begin bad++; $display("FAIL loop_arrived: rx_empty=%b want 0", b_rx_empty); end
    for (int i = 0; i < 3; i++) begin
      pop_b(got);
      e = exp_q.size() ? exp_q.pop_front() : 8'hxx;
      total++; if (got !== e) begin bad++; $display("FAIL loop_data%0d: got %h want %h", i, got, e); end
    end
    total++; if (b_rx_empty !== 1'b1) begin bad++; $display("FAIL loop_drained: rx_empty=%b want 1", b_rx_empty); end
  endtask
  task automatic test_glitch;
    logic [7:0] got;
    b_rx_drv = 1'b0;
    clks(4 * DVSR);
    b_rx_drv = 1'b1;
    clks(2 * FRAME);
    total++; if (b_rx_empty !== 1'b1) begin bad++; $display("FAIL glitch_rejected: rx_empty=%b want 1", b_rx_empty); end
    pop_b(got);
    total++; if (got !== 8'h00) begin bad++; $display("FAIL empty_rd_data: got %h want 00", got); end
    total++; if (b_rx_empty !== 1'b1 || b_rdata !== 8'h00) begin bad++; $display("FAIL empty_pop: rx_empty=%b rd_data=%h want 1/00", b_rx_empty, b_rdata); end
  endtask
  task automatic test_overflow;
    bit ok;
    logic [7:0] d, got, e;
    write_a(8'h10);
    exp_q.push_back(8'h10);
    wait_a_low(ok);
    total++; if (!ok) begin bad++; $display("FAIL ovf_start: tx never went low"); end
    for (int i = 0; i < 16; i++) begin
      total++; if (a_tx_full !== 1'b0) begin bad++; $display("FAIL tx_not_full%0d: got %b want 0", i, a_tx_full); end
      d = 8'h21 + 8'(i * 7);
      write_a(d);
      if (i < 15) exp_q.push_back(d);
    end
    total++; if (a_tx_full !== 1'b1) begin bad++; $display("FAIL tx_full: got %b want 1", a_tx_full); end
    write_a(8'hEE);
    total++; if (a_tx_full !== 1'b1) begin bad++; $display("FAIL tx_full_hold: got %b want 1", a_tx_full); end
    clks(17 * FRAME + FRAME / 4);
    total++; if (b_rx_empty !== 1'b0) begin bad++; $display("FAIL ovf_arrived: rx_empty=%b want 0", b_rx_empty); end
    for (int i = 0; i < 16; i++) begin
      pop_b(got);
      e = exp_q.size() ? exp_q.pop_front() : 8'hxx;
      total++; if (got !== e) begin bad++; $display("FAIL ovf_data%0d: got %h want %h", i, got, e); end
    end
    total++; if (b_rx_empty !== 1'b1) begin bad++; $display("FAIL ovf_dropped: rx_empty=%b want 1", b_rx_empty); end
    clks(2 * FRAME);
    total++; if (b_rx_empty !== 1'b1) begin bad++; $display("FAIL ovf_ignored_write: rx_empty=%b want 1", b_rx_empty); end
    total++; if (a_tx_full !== 1'b0) begin bad++; $display("FAIL tx_drained: tx_full=%b want 0", a_tx_full); end
  endtask
  initial begin
    test_reset;
    test_tx_frame;
    test_reset_mid;
    test_loopback;
    test_glitch;
    test_overflow;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
